// File: rtl/dsp_p_round_sat_fifo.sv
// Output stage for the DSP48A1 slice: delays issue strobes to match P, rounds/saturates P
// to OUT_W bits and queues results in a first-word-fall-through FIFO with valid/ready.
module dsp_p_round_sat_fifo #(
    parameter int LATENCY = 3,
    parameter int SHIFT   = 17,
    parameter int OUT_W   = 18,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     in_valid,
    input  logic [47:0]              P,
    input  logic                     CARRYOUT,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_sat,
    output logic                     out_cy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [48:0] RND   = (SHIFT > 0) ? (49'sd1 <<< RND_SH) : 49'sd0;
    localparam logic signed [48:0] MAX_V = (49'sd1 <<< (OUT_W - 1)) - 49'sd1;
    localparam logic signed [48:0] MIN_V = -(49'sd1 <<< (OUT_W - 1));

    logic [LATENCY-1:0] vpipe;
    logic               tap;

    logic signed [48:0] p_ext;
    logic signed [48:0] r;
    logic [OUT_W-1:0]   res_data;
    logic               res_sat;

    logic [OUT_W-1:0] mem_data [DEPTH];
    logic             mem_sat  [DEPTH];
    logic             mem_cy   [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    // Truncating cast keeps the low LATENCY bits, so LATENCY=1 needs no special case.
    always_ff @(posedge clk) begin
        if (RST) begin
            vpipe <= '0;
        end else begin
            vpipe <= LATENCY'({vpipe, in_valid});
        end
    end

    assign tap = vpipe[LATENCY-1];

    always_comb begin
        p_ext    = {P[47], P};
        r        = (p_ext + RND) >>> SHIFT;
        res_data = r[OUT_W-1:0];
        res_sat  = 1'b0;
        if (r > MAX_V) begin
            res_data = MAX_V[OUT_W-1:0];
            res_sat  = 1'b1;
        end else if (r < MIN_V) begin
            res_data = MIN_V[OUT_W-1:0];
            res_sat  = 1'b1;
        end
    end

    always_comb begin
        out_valid = (cnt != '0);
        full      = (cnt == CW'(DEPTH));
        pop       = out_valid & out_ready;
        push      = tap & (~full | pop);
        drop      = tap & full & ~pop;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= res_data;
            mem_sat[wr_ptr]  <= res_sat;
            mem_cy[wr_ptr]   <= CARRYOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage is not reset; gating the head keeps the outputs zero whenever the FIFO is empty.
    always_comb begin
        out_data = '0;
        out_sat  = 1'b0;
        out_cy   = 1'b0;
        if (out_valid) begin
            out_data = mem_data[rd_ptr];
            out_sat  = mem_sat[rd_ptr];
            out_cy   = mem_cy[rd_ptr];
        end
    end

    assign count = cnt;

endmodule
